// File: rtl/fib_sequencer.sv
// fib_sequencer: Fibonacci engine reporting F(n) with a done pulse or streaming F(0)..F(n) over valid/ready
module fib_sequencer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  input  logic              mode,
  input  logic              abort,
  input  logic              out_ready,
  output logic [DATA_W-1:0] term,
  output logic [IDX_W-1:0]  term_idx,
  output logic              term_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W:0]   sum;
  logic              a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [IDX_W-1:0]  k_q, k_d, n_q, n_d;
  logic              mode_q, mode_d, ovf_q, ovf_d, adv;
  assign term       = a_q;
  assign term_idx   = k_q;
  assign term_valid = state_q == RUN && mode_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign overflow   = ovf_q;
  assign sum        = {1'b0, a_q} + {1'b0, b_q};
  assign adv        = mode_q ? out_ready : 1'b1;
  // next state: start latch in IDLE, abort escape, step/finish in RUN, DONE back to IDLE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    k_d     = k_q;
    n_d     = n_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        n_d     = n_in;
        mode_d  = mode;
        a_d     = '0;
        b_d     = DATA_W'(1);
        k_d     = '0;
        a_ovf_d = 1'b0;
        b_ovf_d = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (abort) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      ovf_d = ovf_q | a_ovf_q;
      if (adv && k_q == n_q) begin
        state_d = DONE;
      end else if (adv) begin
        a_d     = b_q;
        a_ovf_d = b_ovf_q;
        b_d     = sum[DATA_W-1:0];
        b_ovf_d = b_ovf_q | a_ovf_q | sum[DATA_W];
        k_d     = k_q + IDX_W'(1);
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= DATA_W'(1);
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      k_q     <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      k_q     <= k_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
